// File: rtl/holy_week_sequencer.sv
// Holy-week stimulus generator: 14-slot week counter, sabbath calendar, ordered event pulses.
// Latency: all outputs registered and aligned with o_time_of_week; supper lands on slot 2D-1.
// Backpressure: none; the slot counter free-runs and the checker must accept every slot.
module holy_week_sequencer #(
    parameter int CRUCIFIXION_DAY = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    output logic [3:0] o_time_of_week,
    output logic       o_last_supper,
    output logic       o_gethsemane,
    output logic       o_crucifixion,
    output logic       o_preparation_day,
    output logic       o_sabbath,
    output logic       o_request_guards,
    output logic       o_prepare_spices,
    output logic       o_resurrection,
    output logic       o_tomb_visit,
    output logic       o_busy,
    output logic       o_done
);

    if (CRUCIFIXION_DAY < 1 || CRUCIFIXION_DAY > 3) begin : g_bad_day
        $error("holy_week_sequencer: CRUCIFIXION_DAY must be in 1..3");
    end

    localparam logic [3:0] SUPPER_SLOT = 4'(2 * CRUCIFIXION_DAY - 1);
    localparam logic [3:0] HIGH_PREP   = 4'(2 * CRUCIFIXION_DAY + 1);
    localparam logic [3:0] HIGH_SAB_N  = 4'(2 * CRUCIFIXION_DAY + 2);
    localparam logic [3:0] HIGH_SAB_D  = 4'(2 * CRUCIFIXION_DAY + 3);
    localparam logic [3:0] LAST_SLOT   = 4'd13;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t     state_q, state_nxt;
    logic [3:0] slot_q, slot_nxt;
    logic [4:0] k_q, k_nxt;
    logic       run_nxt;
    logic       supper_nxt, geth_nxt, cruc_nxt, guards_nxt, spices_nxt, res_nxt, tomb_nxt;
    logic       sab_nxt, prep_nxt;

    // Everything is decoded from next-cycle state so the registered outputs line up with the slot.
    always_comb begin
        slot_nxt  = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
        state_nxt = state_q;
        k_nxt     = k_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (slot_nxt == SUPPER_SLOT) begin
                        state_nxt = RUN;
                        k_nxt     = 5'd0;
                    end else begin
                        state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                if (slot_nxt == SUPPER_SLOT) begin
                    state_nxt = RUN;
                    k_nxt     = 5'd0;
                end
            end
            RUN: begin
                // k >= 10 means the resurrection (k = 9) is already behind us.
                if (k_q >= 5'd10 && slot_q == 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    k_nxt = k_q + 5'd1;
                end
            end
            default: state_nxt = DONE;
        endcase

        run_nxt    = (state_nxt == RUN);
        supper_nxt = run_nxt && (k_nxt == 5'd0);
        geth_nxt   = run_nxt && (k_nxt == 5'd1);
        cruc_nxt   = run_nxt && (k_nxt == 5'd2);
        guards_nxt = run_nxt && (k_nxt == 5'd4);
        spices_nxt = run_nxt && (k_nxt == 5'd6);
        res_nxt    = run_nxt && (k_nxt == 5'd9);
        tomb_nxt   = run_nxt && (k_nxt >= 5'd10) && (slot_nxt == 4'd1);

        sab_nxt  = (slot_nxt >= 4'd12) || (slot_nxt == HIGH_SAB_N) || (slot_nxt == HIGH_SAB_D);
        prep_nxt = (slot_nxt == 4'd11) || (slot_nxt == HIGH_PREP);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q           <= IDLE;
            slot_q            <= 4'd0;
            k_q               <= 5'd0;
            o_last_supper     <= 1'b0;
            o_gethsemane      <= 1'b0;
            o_crucifixion     <= 1'b0;
            o_request_guards  <= 1'b0;
            o_prepare_spices  <= 1'b0;
            o_resurrection    <= 1'b0;
            o_tomb_visit      <= 1'b0;
            o_sabbath         <= 1'b0;
            o_preparation_day <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            state_q           <= state_nxt;
            slot_q            <= slot_nxt;
            k_q               <= k_nxt;
            o_last_supper     <= supper_nxt;
            o_gethsemane      <= geth_nxt;
            o_crucifixion     <= cruc_nxt;
            o_request_guards  <= guards_nxt;
            o_prepare_spices  <= spices_nxt;
            o_resurrection    <= res_nxt;
            o_tomb_visit      <= tomb_nxt;
            o_sabbath         <= sab_nxt;
            o_preparation_day <= prep_nxt;
            o_busy            <= (state_nxt == ARMED) || run_nxt;
            o_done            <= (state_nxt == DONE);
        end
    end

    assign o_time_of_week = slot_q;

endmodule
